// File: rtl/player_link_pkg.sv
// -----------------------------------------------------------------------------
// dh_link_pkg
// Shared types and default constants for the Duck Hunt inter-board player link.
//   link_game_state_t : game FSM states (PLAY, OVER)
//   DEF_SCORE_W       : default score width in bits
//   DEF_STABLE_CYC    : default stable-cycle count for remote filtering (1 ms @ 65 MHz)
//   DEF_WIN_SCORE     : default winning score
// -----------------------------------------------------------------------------
package dh_link_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } link_game_state_t;

  localparam int DEF_SCORE_W    = 4;
  localparam int DEF_STABLE_CYC = 65000;
  localparam int DEF_WIN_SCORE  = 10;

endpackage

// File: rtl/player_link_if.sv
// -----------------------------------------------------------------------------
// player_link_if
// Bundles the game-logic side and pin side signals of player_link.
//   local_pause/local_reload/local_score : local player state from game logic
//   tx_pause/tx_reload/tx_score          : registered local state to header pins
//   rx_pause_raw/rx_reload_raw/rx_score_raw : asynchronous remote board pins
//   remote_score/remote_reload_pulse     : filtered remote state to game logic
//   global_pause/game_over/winner        : derived game control
// Modports:
//   master : the surrounding board (game logic + pins) that drives the link
//   slave  : player_link itself
// -----------------------------------------------------------------------------
interface player_link_if
  import dh_link_pkg::*;
#(
  parameter int NUM_REMOTE = 1,
  parameter int SCORE_W    = DEF_SCORE_W
);

  localparam int WIN_W = $clog2(NUM_REMOTE + 1);

  logic                          local_pause;
  logic                          local_reload;
  logic [SCORE_W-1:0]            local_score;
  logic                          tx_pause;
  logic                          tx_reload;
  logic [SCORE_W-1:0]            tx_score;
  logic [NUM_REMOTE-1:0]         rx_pause_raw;
  logic [NUM_REMOTE-1:0]         rx_reload_raw;
  logic [NUM_REMOTE*SCORE_W-1:0] rx_score_raw;
  logic [NUM_REMOTE*SCORE_W-1:0] remote_score;
  logic [NUM_REMOTE-1:0]         remote_reload_pulse;
  logic                          global_pause;
  logic                          game_over;
  logic [WIN_W-1:0]              winner;

  modport master (
    output local_pause, local_reload, local_score,
    output rx_pause_raw, rx_reload_raw, rx_score_raw,
    input  tx_pause, tx_reload, tx_score,
    input  remote_score, remote_reload_pulse,
    input  global_pause, game_over, winner
  );

  modport slave (
    input  local_pause, local_reload, local_score,
    input  rx_pause_raw, rx_reload_raw, rx_score_raw,
    output tx_pause, tx_reload, tx_score,
    output remote_score, remote_reload_pulse,
    output global_pause, game_over, winner
  );

endinterface

// File: rtl/player_link_filter.sv
// -----------------------------------------------------------------------------
// link_stable_filter
// 2-FF synchroniser followed by a stability filter for one remote channel.
// The whole WIDTH-bit vector is treated as one value: any bit change restarts
// the stability count.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   i_raw    : asynchronous raw input vector
//   o_filt   : filtered (accepted) value
// Parameters:
//   WIDTH      : vector width
//   STABLE_CYC : consecutive stable cycles before acceptance (>= 2)
//   MONOTONIC  : when set, only accept values >= current output, or zero
// -----------------------------------------------------------------------------
module link_stable_filter
  import dh_link_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter bit MONOTONIC  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt
);

  // The counter saturates at STABLE_CYC-1; the edge that would take it to
  // STABLE_CYC is the one that loads the output, giving STABLE_CYC+3 cycles
  // from raw pin to filtered output (2 sync stages + candidate load).
  localparam int               CNT_W   = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_filt;
  logic             w_accept;

  // In monotonic mode a lower non-zero value is treated as a glitch on the
  // score bus; zero is always allowed so a new game can start.
  assign w_accept = !MONOTONIC || (r_cand >= r_filt) || (r_cand == '0);

  // Synchronise the raw pins, track a candidate value and count how long the
  // synchronised value has matched it. A rejected candidate restarts the count
  // so it is re-evaluated only after another full stable window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_filt  <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_accept) begin
        r_filt <= r_cand;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/player_link.sv
// -----------------------------------------------------------------------------
// player_link
// N-player inter-board link for Duck Hunt. Registers the local player state to
// the outgoing pins, filters the remote boards' pins, and derives global pause
// and the game-over / winner decision.
// Ports:
//   clk, rst : 65 MHz system clock, synchronous active-high reset
//   link     : player_link_if.slave bundle (local, tx, rx, remote, game control)
// Parameters: NUM_REMOTE (1..7), SCORE_W, STABLE_CYC (>= 2), WIN_SCORE
// Build option:
//   SCORE_MONOTONIC_EN : when defined, remote scores may only rise or reset to 0
// -----------------------------------------------------------------------------
module player_link
  import dh_link_pkg::*;
#(
  parameter int NUM_REMOTE = 1,
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int WIN_SCORE  = DEF_WIN_SCORE
) (
  input  logic          clk,
  input  logic          rst,
  player_link_if.slave  link
);

  localparam int                 WIN_W      = $clog2(NUM_REMOTE + 1);
  localparam logic [SCORE_W-1:0] WIN_THRESH = SCORE_W'(WIN_SCORE);

`ifdef SCORE_MONOTONIC_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic [NUM_REMOTE-1:0]         w_rem_pause;
  logic [NUM_REMOTE-1:0]         w_rem_reload;
  logic [NUM_REMOTE*SCORE_W-1:0] w_rem_score;
  logic [NUM_REMOTE-1:0]         r_reload_prev;
  logic                          r_tx_pause;
  logic                          r_tx_reload;
  logic [SCORE_W-1:0]            r_tx_score;
  logic                          r_global_pause;
  link_game_state_t              r_state;
  logic                          r_game_over;
  logic [WIN_W-1:0]              r_winner;
  logic                          w_any_win;
  logic [WIN_W-1:0]              w_win_idx;
  logic                          w_all_zero;

  // One filter per remote channel for each of pause, reload and score.
  for (genvar i = 0; i < NUM_REMOTE; i++) begin : g_remote
    link_stable_filter #(.WIDTH(1), .STABLE_CYC(STABLE_CYC), .MONOTONIC(1'b0)) u_pause (
      .clk(clk), .rst(rst), .i_raw(link.rx_pause_raw[i]), .o_filt(w_rem_pause[i])
    );
    link_stable_filter #(.WIDTH(1), .STABLE_CYC(STABLE_CYC), .MONOTONIC(1'b0)) u_reload (
      .clk(clk), .rst(rst), .i_raw(link.rx_reload_raw[i]), .o_filt(w_rem_reload[i])
    );
    link_stable_filter #(.WIDTH(SCORE_W), .STABLE_CYC(STABLE_CYC), .MONOTONIC(MONO)) u_score (
      .clk(clk), .rst(rst),
      .i_raw(link.rx_score_raw[i*SCORE_W +: SCORE_W]),
      .o_filt(w_rem_score[i*SCORE_W +: SCORE_W])
    );
  end

  // Local state to the pins, global pause, and the previous filtered reload
  // level used to turn a reload rise into a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_pause     <= 1'b0;
      r_tx_reload    <= 1'b0;
      r_tx_score     <= '0;
      r_global_pause <= 1'b0;
      r_reload_prev  <= '0;
    end else begin
      r_tx_pause     <= link.local_pause;
      r_tx_reload    <= link.local_reload;
      r_tx_score     <= link.local_score;
      r_global_pause <= link.local_pause | (|w_rem_pause);
      r_reload_prev  <= w_rem_reload;
    end
  end

  // Winner search: local has top priority; remotes are scanned from the
  // highest index down so the lowest winning index is the one left standing.
  always_comb begin
    w_any_win = 1'b0;
    w_win_idx = '0;
    if (link.local_score >= WIN_THRESH) begin
      w_any_win = 1'b1;
    end else begin
      for (int i = NUM_REMOTE - 1; i >= 0; i--) begin
        if (w_rem_score[i*SCORE_W +: SCORE_W] >= WIN_THRESH) begin
          w_any_win = 1'b1;
          w_win_idx = WIN_W'(i + 1);
        end
      end
    end
  end

  assign w_all_zero = (link.local_score == '0) && (w_rem_score == '0);

  // Game FSM: latch the winner on entry to OVER and hold it until every
  // player's score has returned to zero for a new game.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PLAY;
      r_game_over <= 1'b0;
      r_winner    <= '0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_any_win) begin
            r_state     <= OVER;
            r_game_over <= 1'b1;
            r_winner    <= w_win_idx;
          end
        end
        OVER: begin
          if (w_all_zero) begin
            r_state     <= PLAY;
            r_game_over <= 1'b0;
            r_winner    <= '0;
          end
        end
        default: begin
          r_state     <= PLAY;
          r_game_over <= 1'b0;
          r_winner    <= '0;
        end
      endcase
    end
  end

  assign link.tx_pause            = r_tx_pause;
  assign link.tx_reload           = r_tx_reload;
  assign link.tx_score            = r_tx_score;
  assign link.remote_score        = w_rem_score;
  assign link.remote_reload_pulse = w_rem_reload & ~r_reload_prev;
  assign link.global_pause        = r_global_pause;
  assign link.game_over           = r_game_over;
  assign link.winner              = r_winner;

endmodule
